// File: rtl/gol_sequencer.sv
// Control sequencer for the Game of Life board engine: turns panel buttons and
// switches into registered reset/load/run strobes, row addressing and a generation count.
module gol_sequencer #(
    parameter int HEIGHT   = 20,
    parameter int TICK_DIV = 25000000,
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_btn,
    input  logic                      step_btn,
    input  logic                      clear_btn,
    input  logic                      run_sw,
    input  logic [1:0]                rate_sel,
    output logic                      game_reset,
    output logic                      game_load,
    output logic                      game_run,
    output logic [$clog2(HEIGHT)-1:0] load_row,
    output logic [GEN_W-1:0]          gen_count,
    output logic [2:0]                state
);

    localparam int ROW_W   = $clog2(HEIGHT);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int TICK_W1 = TICK_W + 1;

    localparam logic [ROW_W-1:0]   ROW_FIRST = ROW_W'(1);
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(HEIGHT - 2);
    localparam logic [TICK_W1-1:0] DIV_FULL  = TICK_W1'(TICK_DIV);
    localparam logic [GEN_W-1:0]   GEN_LIMIT = GEN_W'(MAX_GEN);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic load_prev;
    logic step_prev;
    logic clear_prev;
    logic load_edge;
    logic step_edge;
    logic clear_edge;

    logic [TICK_W-1:0]  tick;
    logic [TICK_W1-1:0] period_m1;
    logic               tick_hit;

    logic [GEN_W-1:0] gen_next;
    logic             limit_hit;

    logic reset_nxt;
    logic load_nxt;
    logic run_nxt;

    assign load_edge  = load_btn & ~load_prev;
    assign step_edge  = step_btn & ~step_prev;
    assign clear_edge = clear_btn & ~clear_prev;

    // The period is re-evaluated every cycle, so a rate change takes effect
    // mid-period; an overshooting tick simply wraps around and hits later.
    assign period_m1 = (DIV_FULL >> rate_sel) - TICK_W1'(1);
    assign tick_hit  = ({1'b0, tick} == period_m1);

    assign gen_next  = gen_count + GEN_W'(1);
    assign limit_hit = (MAX_GEN != 0) && (gen_next == GEN_LIMIT);

    assign state = cur_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_CLEAR;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        nxt_state = cur_state;
        if (clear_edge) begin
            nxt_state = S_CLEAR;
        end else begin
            case (cur_state)
                S_CLEAR: nxt_state = S_LOAD;
                S_LOAD: begin
                    if (load_edge && (load_row == ROW_LAST)) begin
                        nxt_state = S_READY;
                    end
                end
                S_READY: begin
                    if (run_sw) begin
                        nxt_state = S_RUN;
                    end else if (step_edge && limit_hit) begin
                        nxt_state = S_HALT;
                    end
                end
                S_RUN: begin
                    if (!run_sw) begin
                        nxt_state = S_READY;
                    end else if (tick_hit && limit_hit) begin
                        nxt_state = S_HALT;
                    end
                end
                S_HALT:  nxt_state = S_HALT;
                default: nxt_state = S_CLEAR;
            endcase
        end
    end

    // Strobe requests; they are registered below so each appears one cycle later.
    always_comb begin
        reset_nxt = (cur_state == S_CLEAR);
        load_nxt  = 1'b0;
        run_nxt   = 1'b0;
        if (!clear_edge) begin
            case (cur_state)
                S_LOAD:  load_nxt = load_edge;
                S_READY: run_nxt  = ~run_sw & step_edge;
                S_RUN:   run_nxt  = run_sw & tick_hit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_prev  <= 1'b0;
            step_prev  <= 1'b0;
            clear_prev <= 1'b0;
            game_reset <= 1'b0;
            game_load  <= 1'b0;
            game_run   <= 1'b0;
            load_row   <= ROW_FIRST;
            gen_count  <= '0;
            tick       <= '0;
        end else begin
            load_prev  <= load_btn;
            step_prev  <= step_btn;
            clear_prev <= clear_btn;
            game_reset <= reset_nxt;
            game_load  <= load_nxt;
            game_run   <= run_nxt;

            if (run_nxt) begin
                gen_count <= gen_next;
            end

            // load_row names the row of the strobe on the bus, then advances.
            if (game_load && (load_row != ROW_LAST)) begin
                load_row <= load_row + ROW_W'(1);
            end

            if ((cur_state == S_RUN) && (nxt_state == S_RUN) && !tick_hit) begin
                tick <= tick + TICK_W'(1);
            end else begin
                tick <= '0;
            end

            if (cur_state == S_CLEAR) begin
                load_row  <= ROW_FIRST;
                gen_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gol_sequencer.sv
// Scoreboard bench for gol_sequencer: the stimulus queues expected strobes,
// per-DUT monitors pop and compare them as strobes appear.
module tb_gol_sequencer;

    localparam int HEIGHT   = 6;
    localparam int TICK_DIV = 16;
    localparam int GEN_W    = 8;

    typedef enum int { EV_RESET = 0, EV_LOAD = 1, EV_RUN = 2 } ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       row;
        int       gen;
        int       cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       load_btn = 1'b0, step_btn = 1'b0, clear_btn = 1'b0, run_sw = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       game_reset, game_load, game_run;
    logic [2:0] load_row;
    logic [GEN_W-1:0] gen_count;
    logic [2:0] state;

    logic       h_load_btn = 1'b0, h_step_btn = 1'b0, h_clear_btn = 1'b0, h_run_sw = 1'b0;
    logic [1:0] h_rate_sel = 2'd0;
    logic       h_game_reset, h_game_load, h_game_run;
    logic [2:0] h_load_row;
    logic [GEN_W-1:0] h_gen_count;
    logic [2:0] h_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a_last_run = -100;
    int h_last_run = -100;
    int t0;

    ev_t a_q[$];
    ev_t h_q[$];
    ev_t a_e;
    ev_t h_e;

    gol_sequencer #(.HEIGHT(HEIGHT), .TICK_DIV(TICK_DIV), .GEN_W(GEN_W), .MAX_GEN(0)) dut (
        .clk(clk), .reset(reset),
        .load_btn(load_btn), .step_btn(step_btn), .clear_btn(clear_btn),
        .run_sw(run_sw), .rate_sel(rate_sel),
        .game_reset(game_reset), .game_load(game_load), .game_run(game_run),
        .load_row(load_row), .gen_count(gen_count), .state(state)
    );

    gol_sequencer #(.HEIGHT(HEIGHT), .TICK_DIV(TICK_DIV), .GEN_W(GEN_W), .MAX_GEN(5)) dut_h (
        .clk(clk), .reset(reset),
        .load_btn(h_load_btn), .step_btn(h_step_btn), .clear_btn(h_clear_btn),
        .run_sw(h_run_sw), .rate_sel(h_rate_sel),
        .game_reset(h_game_reset), .game_load(h_game_load), .game_run(h_game_run),
        .load_row(h_load_row), .gen_count(h_gen_count), .state(h_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic score(input string tag, input ev_t e, input int got, input int row, input int gen);
        check({tag, "_kind"}, got, e.kind);
        check({tag, "_cycle"}, cyc, e.cyc);
        if (e.kind != EV_RUN) check({tag, "_row"}, row, e.row);
        if (e.kind != EV_LOAD) check({tag, "_gen"}, gen, e.gen);
    endtask

    always @(negedge clk) begin
        if (game_reset | game_load | game_run) begin
            check("a_load_run_exclusive", game_load & game_run, 0);
            if (game_run) begin
                check("a_run_spacing", (cyc - a_last_run) >= 2, 1);
                a_last_run = cyc;
            end
            if (a_q.size() == 0) begin
                check("a_unexpected_strobe", {game_reset, game_load, game_run}, 0);
            end else begin
                a_e = a_q.pop_front();
                score("a", a_e, game_reset ? 0 : (game_load ? 1 : 2), load_row, gen_count);
            end
        end
    end

    always @(negedge clk) begin
        if (h_game_reset | h_game_load | h_game_run) begin
            check("h_load_run_exclusive", h_game_load & h_game_run, 0);
            if (h_game_run) begin
                check("h_run_spacing", (cyc - h_last_run) >= 2, 1);
                h_last_run = cyc;
            end
            if (h_q.size() == 0) begin
                check("h_unexpected_strobe", {h_game_reset, h_game_load, h_game_run}, 0);
            end else begin
                h_e = h_q.pop_front();
                score("h", h_e, h_game_reset ? 0 : (h_game_load ? 1 : 2), h_load_row, h_gen_count);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: load_btn    = v;
            1: step_btn    = v;
            2: clear_btn   = v;
            3: h_load_btn  = v;
            4: h_step_btn  = v;
            default: h_clear_btn = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        step(hold);
        set_btn(which, 1'b0);
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_state", state, 0);
        check("rst_load_row", load_row, 1);
        check("rst_gen", gen_count, 0);
        check("rst_strobes", {game_reset, game_load, game_run}, 0);

        reset = 1'b0;
        a_q.push_back('{EV_RESET, 1, 0, cyc + 1});
        h_q.push_back('{EV_RESET, 1, 0, cyc + 1});
        step(1);
        check("post_reset_state", state, 1);

        // step and run are ignored while loading
        press(1, 3);
        run_sw = 1'b1;
        step(3);
        run_sw = 1'b0;
        step(2);
        check("load_ignores_step_row", load_row, 1);
        check("load_ignores_run_state", state, 1);

        for (int k = 1; k <= 4; k++) begin
            a_q.push_back('{EV_LOAD, k, 0, cyc + 1});
            press(0, 2);
        end
        check("loaded_state", state, 2);
        check("loaded_row_hold", load_row, 4);

        for (int k = 1; k <= 3; k++) begin
            a_q.push_back('{EV_RUN, 0, k, cyc + 1});
            press(1, 5);
        end
        check("step_gen", gen_count, 3);
        press(0, 2);
        check("ready_ignores_load_state", state, 2);

        a_q.push_back('{EV_RESET, 1, 0, cyc + 2});
        press(2, 2);
        check("clear_state", state, 1);
        check("clear_gen", gen_count, 0);
        check("clear_row", load_row, 1);

        a_q.push_back('{EV_LOAD, 1, 0, cyc + 1});
        press(0, 2);
        check("row_after_one_load", load_row, 2);

        // clear and load edges together: clear wins, no load strobe
        a_q.push_back('{EV_RESET, 1, 0, cyc + 2});
        load_btn  = 1'b1;
        clear_btn = 1'b1;
        step(2);
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        step(2);
        check("clear_load_row", load_row, 1);
        check("clear_load_state", state, 1);

        for (int k = 1; k <= 4; k++) begin
            a_q.push_back('{EV_LOAD, k, 0, cyc + 1});
            press(0, 2);
        end

        rate_sel = 2'd2;
        t0 = cyc;
        for (int k = 0; k < 3; k++) a_q.push_back('{EV_RUN, 0, k + 1, t0 + 5 + 4 * k});
        run_sw = 1'b1;
        wait_until(t0 + 16);
        run_sw = 1'b0;
        step(20);
        check("run4_state", state, 2);
        check("run4_gen", gen_count, 3);

        rate_sel = 2'd3;
        t0 = cyc;
        for (int k = 0; k < 6; k++) a_q.push_back('{EV_RUN, 0, k + 4, t0 + 3 + 2 * k});
        run_sw = 1'b1;
        wait_until(t0 + 13);
        run_sw = 1'b0;
        step(10);
        check("run2_state", state, 2);
        check("run2_gen", gen_count, 9);

        for (int k = 1; k <= 4; k++) begin
            h_q.push_back('{EV_LOAD, k, 0, cyc + 1});
            press(3, 2);
        end
        check("h_loaded_state", h_state, 2);

        h_rate_sel = 2'd3;
        t0 = cyc;
        for (int k = 0; k < 5; k++) h_q.push_back('{EV_RUN, 0, k + 1, t0 + 3 + 2 * k});
        h_run_sw = 1'b1;
        wait_until(t0 + 11);
        check("h_halt_state", h_state, 4);
        check("h_halt_gen", h_gen_count, 5);
        press(4, 2);
        step(10);
        check("h_halt_hold_state", h_state, 4);
        check("h_halt_hold_gen", h_gen_count, 5);

        h_q.push_back('{EV_RESET, 1, 0, cyc + 2});
        press(5, 2);
        check("h_clear_state", h_state, 1);
        check("h_clear_gen", h_gen_count, 0);
        check("h_clear_row", h_load_row, 1);

        step(5);
        check("a_sb_drained", a_q.size(), 0);
        check("h_sb_drained", h_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
